serial_subtractor: RTL and testbench

Bit-serial N-bit unsigned subtractor built around one full-subtractor cell and a borrow flip-flop. It accepts two operands plus a borrow-in over a valid/ready handshake and processes one bit per clock, LSB first. It returns difference, borrow-out and zero flag over a second valid/ready handshake. This is the sequential datapath stage that drives the 1-bit full-subtractor cell, trading area for latency in wide subtraction.

---
 rtl/serial_subtractor.sv | 123 ++++++++++++
 tb/tb_serial_subtractor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit unsigned subtractor: one full-subtractor cell plus a borrow flop,
// one bit per clock LSB first, with valid/ready handshakes on both sides.
module serial_subtractor #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         borr,
  output logic         zero
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_state_next;

  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_res;
  logic           r_br;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_diff;
  logic           r_borr;
  logic           r_zero;

  logic           w_ai;
  logic           w_bi;
  logic           w_d;
  logic           w_br_next;
  logic           w_last;
  logic [W-1:0]   w_res_next;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  assign w_ai       = r_a[0];
  assign w_bi       = r_b[0];
  assign w_d        = w_ai ^ w_bi ^ r_br;
  assign w_br_next  = (~w_ai & w_bi) | (~w_ai & r_br) | (w_bi & r_br);
  assign w_res_next = W'({w_d, r_res} >> 1);
  assign w_last     = (r_cnt == CW'(W - 1));

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: default assigned first so no path leaves w_state_next unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // NOTE: the shift registers are plain flops, not RAM, so they are reset like all other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_borr <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= bin;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_next;
          r_res <= w_res_next;
          r_cnt <= r_cnt + CW'(1);
          // Visible results update only on the final bit; they hold through IDLE and RUN.
          if (w_last) begin
            r_diff <= w_res_next;
            r_borr <= w_br_next;
            r_zero <= (w_res_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = r_diff;
  assign borr = r_borr;
  assign zero = r_zero;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at W=8 and W=1: directed cases, then
// randomized operations with stalls and ignored-input noise against an arithmetic model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] in_valid;
  logic [1:0] out_ready;
  logic [1:0] bin;
  logic [7:0] a8, b8, diff8;
  logic       a1, b1, diff1;
  logic       rdy8, rdy1, vld8, vld1, borr8, borr1, zero8, zero1;

  int n_pass  = 0;
  int n_total = 0;

  serial_subtractor #(.W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(rdy8),
    .a(a8), .b(b8), .bin(bin[0]), .out_valid(vld8), .out_ready(out_ready[0]),
    .diff(diff8), .borr(borr8), .zero(zero8)
  );

  serial_subtractor #(.W(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(rdy1),
    .a(a1), .b(b1), .bin(bin[1]), .out_valid(vld1), .out_ready(out_ready[1]),
    .diff(diff1), .borr(borr1), .zero(zero1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_rdy(input int u);
    return (u == 0) ? rdy8 : rdy1;
  endfunction

  function automatic logic get_vld(input int u);
    return (u == 0) ? vld8 : vld1;
  endfunction

  function automatic logic [7:0] get_diff(input int u);
    return (u == 0) ? diff8 : {7'b0, diff1};
  endfunction

  function automatic logic get_borr(input int u);
    return (u == 0) ? borr8 : borr1;
  endfunction

  function automatic logic get_zero(input int u);
    return (u == 0) ? zero8 : zero1;
  endfunction

  task automatic drive_ab(input int u, input logic [7:0] av, input logic [7:0] bv);
    if (u == 0) begin
      a8 = av;
      b8 = bv;
    end else begin
      a1 = av[0];
      b1 = bv[0];
    end
  endtask

  // One full operation: offer operands, measure latency, check result, optional
  // backpressure, release. With noise, in_valid/operands/out_ready toggle randomly
  // while the DUT must ignore them.
  task automatic do_op(input int u, input logic [7:0] av, input logic [7:0] bv,
                       input logic bv_in, input int stall, input bit noise);
    int         w;
    int         lat;
    int         guard;
    string      dn;
    logic [8:0] r9;
    logic [1:0] r2;
    logic [7:0] e_diff;
    logic       e_borr;
    logic       e_zero;

    w  = (u == 0) ? 8 : 1;
    dn = (u == 0) ? "w8" : "w1";
    if (u == 0) begin
      r9     = {1'b0, av} - {1'b0, bv} - {8'b0, bv_in};
      e_diff = r9[7:0];
      e_borr = r9[8];
    end else begin
      r2     = {1'b0, av[0]} - {1'b0, bv[0]} - {1'b0, bv_in};
      e_diff = {7'b0, r2[0]};
      e_borr = r2[1];
    end
    e_zero = (e_diff == 8'h00);

    @(negedge clk);
    guard = 0;
    while (!get_rdy(u) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({dn, " in_ready before op"}, 64'(get_rdy(u)), 64'(1));
    in_valid[u] = 1'b1;
    drive_ab(u, av, bv);
    bin[u] = bv_in;
    @(posedge clk);
    @(negedge clk);
    in_valid[u] = 1'b0;
    lat = 0;
    while (!get_vld(u) && lat < 40) begin
      if (noise) begin
        in_valid[u]  = 1'($urandom);
        drive_ab(u, 8'($urandom), 8'($urandom));
        bin[u]       = 1'($urandom);
        out_ready[u] = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    check({dn, " out_valid rises"}, 64'(get_vld(u)), 64'(1));
    check({dn, " latency"}, 64'(lat), 64'(w));
    check({dn, " diff"}, 64'(get_diff(u)), 64'(e_diff));
    check({dn, " borr"}, 64'(get_borr(u)), 64'(e_borr));
    check({dn, " zero"}, 64'(get_zero(u)), 64'(e_zero));
    check({dn, " in_ready in DONE"}, 64'(get_rdy(u)), 64'(0));

    out_ready[u] = 1'b0;
    for (int s = 0; s < stall; s++) begin
      if (noise) begin
        in_valid[u] = 1'b1;
        drive_ab(u, 8'h55, 8'($urandom));
      end
      @(negedge clk);
      check({dn, " stall out_valid"}, 64'(get_vld(u)), 64'(1));
      check({dn, " stall diff"}, 64'(get_diff(u)), 64'(e_diff));
      check({dn, " stall borr"}, 64'(get_borr(u)), 64'(e_borr));
      check({dn, " stall in_ready"}, 64'(get_rdy(u)), 64'(0));
    end

    in_valid[u]  = 1'b0;
    out_ready[u] = 1'b1;
    @(negedge clk);
    out_ready[u] = 1'b0;
    check({dn, " out_valid drops"}, 64'(get_vld(u)), 64'(0));
    check({dn, " in_ready after"}, 64'(get_rdy(u)), 64'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    bin       = '0;
    a8 = '0; b8 = '0; a1 = 1'b0; b1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset in_ready", 64'(rdy8), 64'(1));
    check("reset out_valid", 64'(vld8), 64'(0));
    check("reset diff", 64'(diff8), 64'(0));
    check("reset borr", 64'(borr8), 64'(0));
    check("reset zero", 64'(zero8), 64'(0));
    check("reset w1 in_ready", 64'(rdy1), 64'(1));

    do_op(0, 8'h35, 8'h12, 1'b0, 0, 1'b0);
    do_op(0, 8'h00, 8'h01, 1'b0, 0, 1'b0);
    do_op(0, 8'h10, 8'h0F, 1'b1, 0, 1'b0);
    do_op(0, 8'h80, 8'h01, 1'b0, 6, 1'b1);
    do_op(0, 8'h55, 8'h55, 1'b0, 0, 1'b0);

    // Abort an operation with reset on its third RUN cycle.
    @(negedge clk);
    in_valid[0] = 1'b1;
    a8 = 8'h00;
    b8 = 8'hFF;
    bin[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort out_valid", 64'(vld8), 64'(0));
    check("abort in_ready", 64'(rdy8), 64'(1));
    check("abort diff", 64'(diff8), 64'(0));
    check("abort borr", 64'(borr8), 64'(0));
    check("abort zero", 64'(zero8), 64'(0));
    do_op(0, 8'hFF, 8'hFF, 1'b1, 0, 1'b0);

    for (int u = 0; u < 2; u++) begin
      for (int n = 0; n < 1000; n++) begin
        do_op(u, 8'($urandom), 8'($urandom), 1'($urandom),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 1'b1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
